// File: rtl/gpu_pkg.sv
// gpu_pkg
// Shared definitions for the warp scheduling slice of the core.
//  - CORE_* : encodings of the per-warp core state machine as reported on core_state.
//  - sched_state_t : warp scheduler FSM states.
//  - is_safe_point() : true when the core is in a state where the pipeline owner may change.
package gpu_pkg;

   localparam logic [2:0] CORE_IDLE    = 3'b000;
   localparam logic [2:0] CORE_FETCH   = 3'b001;
   localparam logic [2:0] CORE_DECODE  = 3'b010;
   localparam logic [2:0] CORE_REQUEST = 3'b011;
   localparam logic [2:0] CORE_WAIT    = 3'b100;
   localparam logic [2:0] CORE_EXECUTE = 3'b101;
   localparam logic [2:0] CORE_UPDATE  = 3'b110;
   localparam logic [2:0] CORE_DONE    = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SWAP = 2'd2,
      FIN  = 2'd3
   } sched_state_t;

   // A warp can only be swapped out while it is parked on memory or
   // retiring an instruction; anywhere else its in-flight state would be lost.
   function automatic logic is_safe_point(input logic [2:0] core_state);
      return (core_state == CORE_WAIT) || (core_state == CORE_UPDATE);
   endfunction

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin search: finds the first requesting index after
// ptr, wrapping from N-1 back to 0. The pointer position itself is searched
// last, so callers that want to exclude it must mask it out of req.
// Ports:
//  req   in  N      request mask
//  ptr   in  IDX_W  search starts at ptr+1
//  grant out IDX_W  first requesting index found (0 when none)
//  valid out 1      at least one request was found
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] grant,
   output logic             valid
);

   int unsigned        pos;
   logic [IDX_W-1:0]   idx;

   // Walk every offset once; the first hit wins and later hits are ignored,
   // which gives the round-robin order starting just after the pointer.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      pos   = 0;
      idx   = '0;
      for (int off = 1; off <= N; off++) begin
         pos = (int'(ptr) + off) % N;
         idx = IDX_W'(pos);
         if (!valid && req[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/warp_scheduler.sv
// warp_scheduler
// Decides which warp owns the shared fetch/decode/execute pipeline. The chosen
// index goes to the warp controller, which swaps its per-warp views on the
// following edge; a one-cycle hold (SWAP) lets that registered swap settle.
// Switching only happens at safe points, round-robin, with a time-slice quantum.
// Ports:
//  clk              in  1          core clock
//  reset            in  1          asynchronous, active-high
//  warp_start       in  NUM_WARPS  pulse: warp launched by the dispatcher
//  warp_done        in  NUM_WARPS  level: warp reached DONE
//  warp_mem_pending in  NUM_WARPS  level: warp has an outstanding memory access
//  core_state       in  3          state of the currently selected warp
//  warp_select      out WSEL_W     warp owning the pipeline
//  pipeline_hold    out 1          core must not advance this cycle
//  kernel_done      out 1          every launched warp has finished
//  switch_count     out PERF_W     completed switches, saturating
module warp_scheduler
   import gpu_pkg::*;
#(
   parameter int NUM_WARPS = 2,
   parameter int QUANTUM   = 16,
   parameter int PERF_W    = 16,
   localparam int WSEL_W   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_WARPS-1:0] warp_start,
   input  logic [NUM_WARPS-1:0] warp_done,
   input  logic [NUM_WARPS-1:0] warp_mem_pending,
   input  logic [2:0]           core_state,
   output logic [WSEL_W-1:0]    warp_select,
   output logic                 pipeline_hold,
   output logic                 kernel_done,
   output logic [PERF_W-1:0]    switch_count
);

   localparam int QW = ($clog2(QUANTUM + 1) > 0) ? $clog2(QUANTUM + 1) : 1;
   localparam logic [QW-1:0] QUANTUM_MAX = QW'(QUANTUM);

   sched_state_t           state;
   sched_state_t           state_next;
   logic [WSEL_W-1:0]      select_next;
   logic [NUM_WARPS-1:0]   active;
   logic [NUM_WARPS-1:0]   active_next;
   logic [NUM_WARPS-1:0]   ready;
   logic [NUM_WARPS-1:0]   cur_mask;
   logic [NUM_WARPS-1:0]   arb_req;
   logic [WSEL_W-1:0]      arb_ptr;
   logic [WSEL_W-1:0]      arb_grant;
   logic                   arb_valid;
   logic [QW-1:0]          quantum;
   logic                   quantum_expired;
   logic                   quantum_clear;
   logic                   cur_done;
   logic                   safe_point;

   // A start in the same cycle as a done re-launches the warp, so the set
   // term is applied after the clear term.
   always_comb begin
      active_next = (active & ~warp_done) | warp_start;
      ready       = active & ~warp_done & ~warp_mem_pending;
      cur_mask    = '0;
      cur_mask[warp_select] = 1'b1;
      cur_done    = warp_done[warp_select];
      safe_point  = is_safe_point(core_state);
      // A zero quantum would otherwise look permanently expired.
      quantum_expired = (QUANTUM != 0) && (quantum == QUANTUM_MAX);
   end

   // In IDLE the search starts just after the last index so the lowest ready
   // warp wins; in RUN the current warp is masked out so only a different
   // warp can be picked as the candidate.
   always_comb begin
      arb_req = ready & ~cur_mask;
      arb_ptr = warp_select;
      if (state == IDLE) begin
         arb_req = ready;
         arb_ptr = WSEL_W'(NUM_WARPS - 1);
      end
   end

   rr_arbiter #(
      .N     (NUM_WARPS),
      .IDX_W (WSEL_W)
   ) u_rr_arbiter (
      .req   (arb_req),
      .ptr   (arb_ptr),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   // Next-state and outputs. warp_select only moves on the edge into SWAP,
   // which keeps it stable for every cycle the pipeline is allowed to run.
   always_comb begin
      state_next    = state;
      select_next   = warp_select;
      quantum_clear = 1'b0;
      pipeline_hold = 1'b1;
      kernel_done   = 1'b0;
      case (state)
         IDLE: begin
            if (arb_valid) begin
               select_next = arb_grant;
               state_next  = SWAP;
            end
         end
         RUN: begin
            pipeline_hold = 1'b0;
            if (safe_point) begin
               if ((cur_done || (core_state == CORE_WAIT) || quantum_expired) && arb_valid) begin
                  select_next = arb_grant;
                  state_next  = SWAP;
               end else if (!arb_valid && cur_done) begin
                  // Warps still alive but all stalled on memory: park in IDLE
                  // until one becomes ready rather than declaring completion.
                  state_next = (|active_next) ? IDLE : FIN;
               end else if ((core_state == CORE_UPDATE) && (quantum == QUANTUM_MAX)) begin
                  // Nobody to rotate to; start a fresh slice for the same warp.
                  quantum_clear = 1'b1;
               end
            end
         end
         SWAP: begin
            state_next = RUN;
         end
         FIN: begin
            kernel_done = 1'b1;
            if (|warp_start) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, selection and active mask registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         warp_select <= '0;
         active      <= '0;
      end else begin
         state       <= state_next;
         warp_select <= select_next;
         active      <= active_next;
      end
   end

   // Time-slice counter: counts RUN cycles since the last swap and saturates
   // at the quantum so the expiry stays visible until a safe point arrives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         quantum <= '0;
      end else if (state == SWAP) begin
         quantum <= '0;
      end else if (state == RUN) begin
         if (quantum_clear) begin
            quantum <= '0;
         end else if (quantum != QUANTUM_MAX) begin
            quantum <= quantum + 1'b1;
         end
      end
   end

   // Every SWAP cycle is one completed switch; the counter sticks at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         switch_count <= '0;
      end else if ((state == SWAP) && (switch_count != {PERF_W{1'b1}})) begin
         switch_count <= switch_count + 1'b1;
      end
   end

endmodule
